lut_decoder: RTL and testbench

LUT_DECODER -- requirements
Module: lut_decoder

---
 rtl/lut_decoder.sv | 93 +++++++++
 tb/tb_lut_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_decoder.sv
// Purpose: majority-votes a triple-redundant 4-bit codeword and decodes it to a 3-bit address with error tracking.
// Latency: one cycle from input transfer to out_valid; output register holds under backpressure.
// Backpressure: in_ready follows the output slot (pass-through on out_ready) and drops while status is FAULT.
module lut_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       code_a,
    input  logic [3:0]       code_b,
    input  logic [3:0]       code_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_addr,
    output logic             out_ambig,
    output logic             out_invalid,
    output logic             out_corrected,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       status,
    input  logic             clr
);

    localparam logic [1:0] ST_NORMAL   = 2'b00;
    localparam logic [1:0] ST_DEGRADED = 2'b01;
    localparam logic [1:0] ST_FAULT    = 2'b10;

    logic [3:0] voted;
    logic       dec_corr;
    logic       dec_inval;
    logic       dec_amb;
    logic [2:0] dec_addr;
    logic       xfer_in;

    assign in_ready = (!out_valid || out_ready) && (status != ST_FAULT);
    assign xfer_in  = in_valid && in_ready;

    assign voted    = (code_a & code_b) | (code_a & code_c) | (code_b & code_c);
    assign dec_corr = (code_a != voted) || (code_b != voted) || (code_c != voted);

    always_comb begin
        dec_addr  = 3'b000;
        dec_amb   = 1'b0;
        dec_inval = 1'b0;
        case (voted)
            4'b0000: dec_addr = 3'b000;
            4'b1010: begin dec_addr = 3'b001; dec_amb = 1'b1; end
            4'b0110: dec_addr = 3'b011;
            4'b1001: dec_addr = 3'b100;
            4'b0101: begin dec_addr = 3'b101; dec_amb = 1'b1; end
            4'b1111: dec_addr = 3'b111;
            default: dec_inval = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_addr      <= 3'b000;
            out_ambig     <= 1'b0;
            out_invalid   <= 1'b0;
            out_corrected <= 1'b0;
        end else if (xfer_in) begin
            out_valid     <= 1'b1;
            out_addr      <= dec_addr;
            out_ambig     <= dec_amb;
            out_invalid   <= dec_inval;
            out_corrected <= dec_corr;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // clr outranks both the counter increment and any status transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            status  <= ST_NORMAL;
        end else if (clr) begin
            err_cnt <= '0;
            status  <= ST_NORMAL;
        end else if (xfer_in) begin
            if ((dec_corr || dec_inval) && (err_cnt != {CNT_W{1'b1}}))
                err_cnt <= err_cnt + CNT_W'(1);
            if (dec_inval)
                status <= ST_FAULT;
            else if (dec_corr && status == ST_NORMAL)
                status <= ST_DEGRADED;
        end
    end

endmodule

// File: tb/tb_lut_decoder.sv
// Scoreboard bench for lut_decoder: directed scenarios followed by random traffic against a table-driven reference.
module tb_lut_decoder;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       code_a = '0, code_b = '0, code_c = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       out_addr;
    logic             out_ambig, out_invalid, out_corrected;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       status;
    logic             clr = 1'b0;

    lut_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .code_a(code_a), .code_b(code_b), .code_c(code_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_ambig(out_ambig), .out_invalid(out_invalid), .out_corrected(out_corrected),
        .err_cnt(err_cnt), .status(status), .clr(clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] addr;
        logic       amb;
        logic       inv;
        logic       cor;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    logic [3:0] codes [6] = '{4'b0000, 4'b1010, 4'b0110, 4'b1001, 4'b0101, 4'b1111};
    logic [2:0] addrs [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd7};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        exp_t r;
        logic [3:0] v;
        for (int i = 0; i < 4; i++)
            v[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        r.cor  = (a != v) || (b != v) || (c != v);
        r.inv  = 1'b1;
        r.addr = 3'd0;
        r.amb  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (v == codes[k]) begin
                r.inv  = 1'b0;
                r.addr = addrs[k];
                r.amb  = (v == 4'b1010) || (v == 4'b0101);
            end
        end
        return r;
    endfunction

    // Reference state: output-slot occupancy, error count, status (0 normal, 1 degraded, 2 fault)
    int ov_m = 0;
    int cnt_m = 0;
    int st_m = 0;

    initial begin : model_proc
        int   exp_rdy;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_addr", out_addr, 0);
                chk("rst_out_ambig", out_ambig, 0);
                chk("rst_out_invalid", out_invalid, 0);
                chk("rst_out_corrected", out_corrected, 0);
                chk("rst_err_cnt", err_cnt, 0);
                chk("rst_status", status, 0);
                ov_m = 0; cnt_m = 0; st_m = 0;
                q.delete();
            end else begin
                exp_rdy = ((ov_m == 0) || out_ready) && (st_m != 2);
                chk("out_valid", out_valid, ov_m);
                chk("in_ready", in_ready, exp_rdy);
                chk("err_cnt", err_cnt, cnt_m);
                chk("status", status, st_m);
                e = ref_decode(code_a, code_b, code_c);
                if (in_valid && exp_rdy) q.push_back(e);
                if (clr) begin
                    cnt_m = 0;
                    st_m  = 0;
                end else if (in_valid && exp_rdy) begin
                    if ((e.cor || e.inv) && cnt_m < CNT_MAX) cnt_m++;
                    if (e.inv) st_m = 2;
                    else if (e.cor && st_m == 0) st_m = 1;
                end
                if (in_valid && exp_rdy) ov_m = 1;
                else if (out_ready) ov_m = 0;
            end
        end
    end

    // Output monitor: every cycle out_valid is high the held result must match the oldest accepted word
    initial begin : monitor_proc
        exp_t h;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    h = q[0];
                    chk("out_addr", out_addr, h.addr);
                    chk("out_ambig", out_ambig, h.amb);
                    chk("out_invalid", out_invalid, h.inv);
                    chk("out_corrected", out_corrected, h.cor);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        in_valid = v; code_a = a; code_b = b; code_c = c;
    endtask

    initial begin : driver
        logic [3:0] base;
        logic [3:0] ca, cb, cc;
        repeat (3) step();
        rst_n = 1'b1;

        // clean sweep
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            put(1'b1, codes[k], codes[k], codes[k]);
            step();
        end
        put(1'b0, 4'd0, 4'd0, 4'd0);
        step();
        @(negedge clk);
        chk("sweep_err_cnt", err_cnt, 0);
        chk("sweep_status", status, 0);

        // single-copy fault
        step();
        put(1'b1, 4'b1010, 4'b1010, 4'b1011);
        step();
        #1 chk("single_addr", out_addr, 1);
        chk("single_corrected", out_corrected, 1);
        chk("single_invalid", out_invalid, 0);
        put(1'b0, 4'd0, 4'd0, 4'd0);
        step();
        @(negedge clk);
        chk("single_err_cnt", err_cnt, 1);
        chk("single_status", status, 1);

        // invalid word drives FAULT; held input must not be taken
        step();
        put(1'b1, 4'b0011, 4'b0011, 4'b0011);
        repeat (3) step();
        @(negedge clk);
        chk("fault_status", status, 2);
        chk("fault_in_ready", in_ready, 0);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        put(1'b0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_status", status, 0);

        // backpressure
        step();
        out_ready = 1'b0;
        put(1'b1, 4'b0110, 4'b0110, 4'b0110);
        step();
        put(1'b1, 4'b1001, 4'b1001, 4'b1001);
        repeat (3) step();
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_addr_held", out_addr, 3);
        step();
        out_ready = 1'b1;
        step();
        put(1'b0, 4'd0, 4'd0, 4'd0);
        repeat (2) step();

        // saturation of the narrow counter, then clr colliding with a corrected word
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(1'b1, 4'b0000, 4'b0000, 4'b0001);
            step();
        end
        put(1'b0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        chk("sat_err_cnt", err_cnt, 3);
        step();
        clr = 1'b1;
        put(1'b1, 4'b1111, 4'b1110, 4'b1111);
        step();
        clr = 1'b0;
        put(1'b0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        chk("clr_vs_incr_err_cnt", err_cnt, 0);
        chk("clr_vs_incr_status", status, 0);

        // reset while a result is held
        step();
        out_ready = 1'b0;
        put(1'b1, 4'b1111, 4'b1111, 4'b1111);
        step();
        put(1'b0, 4'd0, 4'd0, 4'd0);
        step();
        rst_n = 1'b0;
        #1 chk("midrst_out_valid", out_valid, 0);
        repeat (2) step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            base = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)];
            ca = base; cb = base; cc = base;
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0: ca[$urandom_range(0, 3)] ^= 1'b1;
                    1: cb[$urandom_range(0, 3)] ^= 1'b1;
                    default: cc[$urandom_range(0, 3)] ^= 1'b1;
                endcase
            end
            if ($urandom_range(0, 9) == 0) begin
                ca = 4'($urandom); cb = 4'($urandom); cc = 4'($urandom);
            end
            put($urandom_range(0, 3) != 0, ca, cb, cc);
            out_ready = $urandom_range(0, 3) != 0;
            clr = $urandom_range(0, 15) == 0;
            step();
        end

        put(1'b0, 4'd0, 4'd0, 4'd0);
        out_ready = 1'b1;
        clr = 1'b0;
        repeat (3) step();
        chk("drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
